// File: rtl/alarm_pkg.sv
// Shared state encoding and default parameter values for the accident-alarm sequencer.
package alarm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_QUAL      = 3'd1,
    ST_ALARM     = 3'd2,
    ST_ESCALATED = 3'd3,
    ST_CLEARING  = 3'd4
  } state_t;

  localparam int DEF_DEBOUNCE_CYC = 4;
  localparam int DEF_BLINK_HALF   = 8;
  localparam int DEF_ESC_TIMEOUT  = 64;
  localparam logic [7:0] EVENT_MAX = 8'd255;

  function automatic logic is_latched(input state_t s);
    return (s == ST_ALARM) || (s == ST_ESCALATED);
  endfunction

endpackage

// File: rtl/alarm_blink_gen.sv
// Siren blink generator: high for the first BLINK_HALF enabled cycles, then toggles every BLINK_HALF.
// Control inputs describe the coming cycle, so the siren register is valid right after the edge.
module alarm_blink_gen #(
  parameter int BLINK_HALF = alarm_pkg::DEF_BLINK_HALF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  logic hold,
  output logic siren
);

  localparam logic [7:0] HALF_LAST = 8'(BLINK_HALF - 1);

  logic [7:0] cnt_reg;
  logic       run_reg;
  logic       siren_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg   <= '0;
      run_reg   <= 1'b0;
      siren_reg <= 1'b0;
    end else if (clr) begin
      cnt_reg   <= '0;
      run_reg   <= 1'b0;
      siren_reg <= 1'b0;
    end else if (hold) begin
      cnt_reg   <= '0;
      run_reg   <= 1'b0;
      siren_reg <= 1'b1;
    end else if (en) begin
      // First enabled cycle always starts in the "on" phase.
      if (!run_reg) begin
        run_reg   <= 1'b1;
        cnt_reg   <= '0;
        siren_reg <= 1'b1;
      end else if (cnt_reg == HALF_LAST) begin
        cnt_reg   <= '0;
        siren_reg <= ~siren_reg;
      end else begin
        cnt_reg <= cnt_reg + 8'd1;
      end
    end
  end

  assign siren = siren_reg;

endmodule

// File: rtl/alarm_seq_ctrl.sv
// Accident-alarm sequencer: debounce, latch, blinking siren, operator ack and clear-on-release.
// Define ALARM_ESCALATE_EN to build the escalation timer, ESCALATED state and call_out.
module alarm_seq_ctrl
  import alarm_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int BLINK_HALF   = DEF_BLINK_HALF,
  parameter int ESC_TIMEOUT  = DEF_ESC_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       alarm_in,
  input  logic       ack,
  output logic       active,
  output logic       siren,
  output logic       call_out,
  output logic [7:0] event_cnt,
  output logic [2:0] state_o
);

  state_t     state_reg;
  state_t     state_next;
  logic [3:0] qual_cnt_reg;
  logic [7:0] event_cnt_reg;
  logic       active_reg;
  logic       esc_expire;
  logic       blink_en;
  logic       blink_hold;
  logic       blink_clr;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (alarm_in) state_next = (DEBOUNCE_CYC == 1) ? ST_ALARM : ST_QUAL;
      end
      ST_QUAL: begin
        if (!alarm_in)                                  state_next = ST_IDLE;
        else if (int'(qual_cnt_reg) + 1 == DEBOUNCE_CYC) state_next = ST_ALARM;
      end
      ST_ALARM: begin
        // ack takes priority over a coincident timeout.
        if (ack)             state_next = ST_CLEARING;
        else if (esc_expire) state_next = ST_ESCALATED;
      end
      ST_ESCALATED: begin
        if (ack) state_next = ST_CLEARING;
      end
      ST_CLEARING: begin
        if (!alarm_in) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign blink_en   = (state_next == ST_ALARM);
  assign blink_hold = (state_next == ST_ESCALATED);
  assign blink_clr  = !(blink_en || blink_hold);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      qual_cnt_reg  <= '0;
      event_cnt_reg <= '0;
      active_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      qual_cnt_reg <= (state_next == ST_QUAL) ? qual_cnt_reg + 4'd1 : 4'd0;
      active_reg   <= is_latched(state_next);
      if (state_next == ST_ALARM && state_reg != ST_ALARM && event_cnt_reg != EVENT_MAX)
        event_cnt_reg <= event_cnt_reg + 8'd1;
    end
  end

`ifdef ALARM_ESCALATE_EN
  localparam logic [15:0] ESC_LAST = 16'(ESC_TIMEOUT - 1);

  logic [15:0] esc_cnt_reg;
  logic        call_out_reg;

  assign esc_expire = (esc_cnt_reg == ESC_LAST);

  // Timer is zero in the first ALARM cycle and counts every ALARM cycle after.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      esc_cnt_reg  <= '0;
      call_out_reg <= 1'b0;
    end else begin
      esc_cnt_reg  <= (state_reg == ST_ALARM && state_next == ST_ALARM) ? esc_cnt_reg + 16'd1 : 16'd0;
      call_out_reg <= (state_next == ST_ESCALATED);
    end
  end

  assign call_out = call_out_reg;
`else
  assign esc_expire = 1'b0;
  assign call_out   = 1'b0;
`endif

  alarm_blink_gen #(
    .BLINK_HALF(BLINK_HALF)
  ) u_blink (
    .clk  (clk),
    .rst  (rst),
    .en   (blink_en),
    .clr  (blink_clr),
    .hold (blink_hold),
    .siren(siren)
  );

  assign active    = active_reg;
  assign event_cnt = event_cnt_reg;
  assign state_o   = state_reg;

endmodule

// File: doc/alarm_seq_ctrl.md
ALARM_SEQ_CTRL -- requirements
Module: alarm_seq_ctrl

Interface
REQ-001 The block SHALL have exactly one clock and an asynchronous, active-high reset.
REQ-002 Parameter DEBOUNCE_CYC, default 4: consecutive high samples of alarm_in needed to latch an alarm (range 1..15).
REQ-003 Parameter BLINK_HALF, default 8: siren half-period in cycles (range 1..255).
REQ-004 Parameter ESC_TIMEOUT, default 64: cycles in ALARM with no ack before escalation (range 2..65535).
REQ-005 Port clk, input, 1: rising-edge clock.
REQ-006 Port rst, input, 1: asynchronous active-high reset.
REQ-007 Port alarm_in, input, 1: raw accident-alarm flag from the combinational alarm decoder (its o output), synchronous to clk.
REQ-008 Port ack, input, 1: operator acknowledge, level-sampled each cycle.
REQ-009 Port active, output, 1: high while an alarm is latched (ALARM or ESCALATED).
REQ-010 Port siren, output, 1: siren drive.
REQ-011 Port call_out, output, 1: external emergency call request.
REQ-012 Port event_cnt, output, 8: count of alarms latched since reset, saturating.
REQ-013 Port state_o, output, 3: current state encoding, for debug.

Function
REQ-014 States SHALL be IDLE=0, QUAL=1, ALARM=2, ESCALATED=3, CLEARING=4; all outputs are registered.
REQ-015 IDLE: alarm_in=1 moves to QUAL with qual count 1; if DEBOUNCE_CYC=1 it moves directly to ALARM instead.
REQ-016 QUAL: alarm_in=1 increments the qual count, and the edge taking the DEBOUNCE_CYC-th consecutive high sample moves to ALARM.
REQ-017 QUAL: alarm_in=0 on any sample returns to IDLE and clears the qual count; glitches shorter than DEBOUNCE_CYC never latch.
REQ-018 Latency: with alarm_in first high at edge k and held, active SHALL be 1 after edge k+DEBOUNCE_CYC-1.
REQ-019 On every entry to ALARM, event_cnt SHALL increment by 1 and saturate at 255.
REQ-020 ALARM: active=1; siren is 1 for the first BLINK_HALF cycles, then toggles every BLINK_HALF cycles.
REQ-021 ALARM: the escalation timer starts at 0 on entry and increments each cycle.
REQ-022 ALARM: ack=1 moves to CLEARING on the next edge, regardless of alarm_in.
REQ-023 ESCALATED: active=1, siren held at constant 1, call_out=1; ack=1 moves to CLEARING.
REQ-024 CLEARING: active, siren and call_out are 0; the block stays here while alarm_in=1 and moves to IDLE on the first alarm_in=0 sample, so a persisting fault cannot re-trigger.
REQ-025 Simultaneous ack and timeout expiry in ALARM: ack wins and the next state is CLEARING.
REQ-026 ack in IDLE, QUAL or CLEARING SHALL be ignored.
REQ-027 alarm_in falling while in ALARM or ESCALATED SHALL NOT clear the alarm; only ack clears it.

Reset
REQ-028 When rst is asserted, the block SHALL immediately enter IDLE with active=0, siren=0, call_out=0, event_cnt=0, state_o=0, and all counters cleared, including mid-alarm.
REQ-029 After rst deasserts, the first edge SHALL sample alarm_in as a fresh qualification start.

Configuration
REQ-030 Macro ALARM_ESCALATE_EN SHALL control escalation.
REQ-031 With ALARM_ESCALATE_EN defined, ALARM moves to ESCALATED on the edge where the timer reaches ESC_TIMEOUT-1 with ack=0.
REQ-032 Without ALARM_ESCALATE_EN, the escalation timer and ESCALATED state are not built, ALARM persists until ack, call_out is tied to 0, and ESCALATED is unreachable.

Structure
REQ-033 A shared package alarm_pkg SHALL hold the state enum/encoding constants and the default parameter values.
REQ-034 A sub-module alarm_blink_gen SHALL implement the BLINK_HALF toggle counter, with enable and sync-clear inputs and a siren output.

Verification (defaults D=4, B=8, T=64, macro defined unless stated)
REQ-035 Scenario: alarm_in high for 3 cycles then low -> state returns to IDLE, active stays 0, event_cnt=0.
REQ-036 Scenario: alarm_in held high from edge 10 -> active=1 after edge 13, event_cnt=1, siren=1 for 8 cycles then 0 for 8.
REQ-037 Scenario: latched alarm, ack at 20 cycles into ALARM with alarm_in still 1 -> CLEARING with outputs 0; alarm_in low -> IDLE; no re-latch while alarm_in stays high.
REQ-038 Scenario: no ack -> call_out=1 and siren steady 1 after 64 cycles in ALARM; ack coincident with the expiry edge -> CLEARING with call_out remaining 0.
REQ-039 Scenario: rst pulsed during ESCALATED -> all outputs 0 asynchronously before the next clk edge, and event_cnt=0.
REQ-040 Scenario: macro undefined, no ack for 200 cycles -> call_out=0, siren keeps toggling, state_o=2 throughout.
